// File: rtl/apogeo_pkg.sv
// Shared ROB types: entry payload and tag.
// Imported by reorder_buffer and rob_memory.
package apogeo_pkg;

  localparam int ROB_DEPTH_DEF = 32;
  localparam int ROB_TW = $clog2(ROB_DEPTH_DEF);

  typedef logic [ROB_TW-1:0] rob_tag_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        csr;
    logic        exc;
    logic [4:0]  vector;
    logic [31:0] addr;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_memory.sv
// Payload store for the ROB: 1 write port, async read, no reset.
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i, rdata_o.
module rob_memory
  import apogeo_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  rob_entry_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output rob_entry_t    rdata_o
);

  rob_entry_t mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit: results arrive by tag, retire in tag order.
// Ports: issue/rollback/flush/stall, result write, writeback, exception.
// Option ROB_BYPASS_EN: a result for an empty head retires same cycle.
module reorder_buffer
  import apogeo_pkg::*;
#(
  parameter int ROB_DEPTH = 32,
  localparam int TW = $clog2(ROB_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic          stall_i,
  input  logic          issue_i,
  input  logic          rollback_i,
  output logic          full_o,
  input  logic          result_valid_i,
  input  logic [TW-1:0] result_tag_i,
  input  logic [31:0]   result_data_i,
  input  logic [4:0]    result_reg_i,
  input  logic          result_csr_i,
  input  logic          result_exception_i,
  input  logic [4:0]    result_vector_i,
  input  logic [31:0]   result_addr_i,
  output logic [TW-1:0] head_tag_o,
  output logic          writeback_o,
  output logic [4:0]    writeback_register_o,
  output logic [31:0]   writeback_data_o,
  output logic          csr_writeback_o,
  output logic          exception_o,
  output logic [4:0]    exception_vector_o,
  output logic [31:0]   exception_addr_o
);

  localparam int CW = TW + 1;

  logic [TW-1:0]        head_q;
  logic [TW-1:0]        tail_q;
  logic [TW-1:0]        tail_m1;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [ROB_DEPTH-1:0] vld_q;
  logic [ROB_DEPTH-1:0] vld_d;

  logic       iss_ok;
  logic       rb_ok;
  logic       ret_arr;
  logic       byp;
  logic       ret;
  logic       wr_en;
  rob_entry_t in_ent;
  rob_entry_t rd_ent;
  rob_entry_t ent;

  assign in_ent = '{
    data:   result_data_i,
    rd:     result_reg_i,
    csr:    result_csr_i,
    exc:    result_exception_i,
    vector: result_vector_i,
    addr:   result_addr_i
  };

  rob_memory #(
    .DEPTH (ROB_DEPTH),
    .AW    (TW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (result_tag_i),
    .wdata_i (in_ent),
    .raddr_i (head_q),
    .rdata_o (rd_ent)
  );

  assign full_o  = (cnt_q == CW'(ROB_DEPTH));
  assign tail_m1 = tail_q - TW'(1);
  assign rb_ok   = rollback_i & (cnt_q != '0);
  assign iss_ok  = issue_i & !full_o & !rb_ok;
  assign ret_arr = vld_q[head_q] & !stall_i & !flush_i;

`ifdef ROB_BYPASS_EN
  assign byp = result_valid_i & (result_tag_i == head_q)
             & !vld_q[head_q] & !stall_i & !flush_i;
`else
  assign byp = 1'b0;
`endif

  assign ret   = ret_arr | byp;
  assign wr_en = result_valid_i & !byp;
  assign ent   = byp ? in_ent : rd_ent;

  assign cnt_d = cnt_q + CW'(iss_ok) - CW'(rb_ok) - CW'(ret);

  always_comb begin
    vld_d = vld_q;
    if (wr_en)   vld_d[result_tag_i] = 1'b1;
    if (ret_arr) vld_d[head_q] = 1'b0;
    if (rb_ok)   vld_d[tail_m1] = 1'b0;
    if (flush_i) vld_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      if (ret) head_q <= head_q + TW'(1);
      if (rb_ok) tail_q <= tail_m1;
      else if (iss_ok) tail_q <= tail_q + TW'(1);
    end
  end

  logic wb;
  logic cw;
  logic ex;

  assign wb = ret & !ent.exc & !ent.csr & (ent.rd != '0);
  assign cw = ret & !ent.exc & ent.csr;
  assign ex = ret & ent.exc;

  assign head_tag_o           = head_q;
  assign writeback_o          = wb;
  assign writeback_register_o = wb ? ent.rd : '0;
  assign writeback_data_o     = wb ? ent.data : '0;
  assign csr_writeback_o      = cw;
  assign exception_o          = ex;
  assign exception_vector_o   = ex ? ent.vector : '0;
  assign exception_addr_o     = ex ? ent.addr : '0;

  a_no_overwrite: assert property (
    @(posedge clk_i) disable iff (!rst_n_i)
    result_valid_i |-> !vld_q[result_tag_i]
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer (default build, no bypass).
// Table of per-cycle vectors plus hand sequences for full/reset.
module tb_reorder_buffer;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i, stall_i, issue_i, rollback_i;
  logic        full_o;
  logic        result_valid_i;
  logic [4:0]  result_tag_i;
  logic [31:0] result_data_i;
  logic [4:0]  result_reg_i;
  logic        result_csr_i, result_exception_i;
  logic [4:0]  result_vector_i;
  logic [31:0] result_addr_i;
  logic [4:0]  head_tag_o;
  logic        writeback_o;
  logic [4:0]  writeback_register_o;
  logic [31:0] writeback_data_o;
  logic        csr_writeback_o, exception_o;
  logic [4:0]  exception_vector_o;
  logic [31:0] exception_addr_o;

  always #5 clk_i = ~clk_i;

  reorder_buffer #(.ROB_DEPTH(32)) dut (
    .clk_i                (clk_i),
    .rst_n_i              (rst_n_i),
    .flush_i              (flush_i),
    .stall_i              (stall_i),
    .issue_i              (issue_i),
    .rollback_i           (rollback_i),
    .full_o               (full_o),
    .result_valid_i       (result_valid_i),
    .result_tag_i         (result_tag_i),
    .result_data_i        (result_data_i),
    .result_reg_i         (result_reg_i),
    .result_csr_i         (result_csr_i),
    .result_exception_i   (result_exception_i),
    .result_vector_i      (result_vector_i),
    .result_addr_i        (result_addr_i),
    .head_tag_o           (head_tag_o),
    .writeback_o          (writeback_o),
    .writeback_register_o (writeback_register_o),
    .writeback_data_o     (writeback_data_o),
    .csr_writeback_o      (csr_writeback_o),
    .exception_o          (exception_o),
    .exception_vector_o   (exception_vector_o),
    .exception_addr_o     (exception_addr_o)
  );

  typedef struct packed {
    logic        full;
    logic [4:0]  head;
    logic        wb;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        csr;
    logic        exc;
    logic [4:0]  evec;
    logic [31:0] eaddr;
  } obs_t;

  typedef struct {
    logic        fl, st, is, rb, rv;
    logic [4:0]  tag, rd;
    logic [31:0] data;
    logic        csr, exc;
    logic [4:0]  vec;
    logic [31:0] addr;
    obs_t        e;
  } vec_t;

  int checks = 0;
  int failures = 0;

  function automatic obs_t on(int h);
    obs_t o = '0;
    o.head = 5'(h);
    return o;
  endfunction

  function automatic obs_t ow(int h, int r, logic [31:0] d);
    obs_t o = on(h);
    o.wb = 1'b1;
    o.wreg = 5'(r);
    o.wdata = d;
    return o;
  endfunction

  function automatic obs_t oc(int h);
    obs_t o = on(h);
    o.csr = 1'b1;
    return o;
  endfunction

  function automatic obs_t oe(int h, int v, logic [31:0] a);
    obs_t o = on(h);
    o.exc = 1'b1;
    o.evec = 5'(v);
    o.eaddr = a;
    return o;
  endfunction

  function automatic vec_t ctl(logic fl, logic st, logic is,
                               logic rb, obs_t e);
    vec_t v;
    v.fl = fl; v.st = st; v.is = is; v.rb = rb;
    v.rv = 1'b0; v.tag = '0; v.rd = '0; v.data = '0;
    v.csr = 1'b0; v.exc = 1'b0; v.vec = '0; v.addr = '0;
    v.e = e;
    return v;
  endfunction

  function automatic vec_t wr(int t, int r, logic [31:0] d,
                              logic c, logic x, int vc,
                              logic [31:0] a, logic st, obs_t e);
    vec_t v = ctl(1'b0, st, 1'b0, 1'b0, e);
    v.rv = 1'b1; v.tag = 5'(t); v.rd = 5'(r); v.data = d;
    v.csr = c; v.exc = x; v.vec = 5'(vc); v.addr = a;
    return v;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.full  = full_o;
    o.head  = head_tag_o;
    o.wb    = writeback_o;
    o.wreg  = writeback_register_o;
    o.wdata = writeback_data_o;
    o.csr   = csr_writeback_o;
    o.exc   = exception_o;
    o.evec  = exception_vector_o;
    o.eaddr = exception_addr_o;
    return o;
  endfunction

  task automatic chk(string nm, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    flush_i = 0; stall_i = 0; issue_i = 0; rollback_i = 0;
    result_valid_i = 0; result_tag_i = '0; result_data_i = '0;
    result_reg_i = '0; result_csr_i = 0; result_exception_i = 0;
    result_vector_i = '0; result_addr_i = '0;
  endtask

  task automatic drive(vec_t v);
    flush_i = v.fl; stall_i = v.st; issue_i = v.is;
    rollback_i = v.rb; result_valid_i = v.rv;
    result_tag_i = v.tag; result_data_i = v.data;
    result_reg_i = v.rd; result_csr_i = v.csr;
    result_exception_i = v.exc; result_vector_i = v.vec;
    result_addr_i = v.addr;
  endtask

  vec_t tbl[$];
  obs_t ex;

  initial begin
    // in-order retirement
    tbl.push_back(ctl(0, 0, 0, 0, on(0)));
    tbl.push_back(ctl(0, 0, 1, 0, on(0)));
    tbl.push_back(ctl(0, 0, 1, 0, on(0)));
    tbl.push_back(ctl(0, 0, 1, 0, on(0)));
    tbl.push_back(wr(2, 5, 'hAA, 0, 0, 0, 0, 0, on(0)));
    tbl.push_back(wr(0, 1, 'h11, 0, 0, 0, 0, 0, on(0)));
    tbl.push_back(wr(1, 3, 'h33, 0, 0, 0, 0, 0, ow(0, 1, 'h11)));
    tbl.push_back(ctl(0, 0, 0, 0, ow(1, 3, 'h33)));
    tbl.push_back(ctl(0, 0, 0, 0, ow(2, 5, 'hAA)));
    tbl.push_back(ctl(0, 0, 0, 0, on(3)));
    // exception, x0, csr
    tbl.push_back(ctl(0, 0, 1, 0, on(3)));
    tbl.push_back(ctl(0, 0, 1, 0, on(3)));
    tbl.push_back(ctl(0, 0, 1, 0, on(3)));
    tbl.push_back(wr(3, 7, 'hDEAD, 0, 1, 2, 'h100, 0, on(3)));
    tbl.push_back(wr(4, 0, 'h55, 0, 0, 0, 0, 0, oe(3, 2, 'h100)));
    tbl.push_back(wr(5, 9, 'h77, 1, 0, 0, 0, 0, on(4)));
    tbl.push_back(ctl(0, 0, 0, 0, oc(5)));
    tbl.push_back(ctl(0, 0, 0, 0, on(6)));
    // stall then flush
    tbl.push_back(ctl(0, 0, 1, 0, on(6)));
    tbl.push_back(wr(6, 2, 'h22, 0, 0, 0, 0, 1, on(6)));
    tbl.push_back(ctl(0, 1, 0, 0, on(6)));
    tbl.push_back(ctl(0, 1, 0, 0, on(6)));
    tbl.push_back(ctl(0, 1, 0, 0, on(6)));
    tbl.push_back(ctl(1, 0, 0, 0, on(6)));
    tbl.push_back(ctl(0, 0, 0, 0, on(0)));
    // rollback: issue 2, roll back 1, issue 1 -> count 2
    tbl.push_back(ctl(0, 0, 1, 0, on(0)));
    tbl.push_back(ctl(0, 0, 1, 0, on(0)));
    tbl.push_back(ctl(0, 0, 0, 1, on(0)));
    tbl.push_back(ctl(0, 0, 1, 0, on(0)));

    idle();
    rst_n_i = 1'b0;
    #1;
    chk("reset_state", sample(), on(0));
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk_i);
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d", i), sample(), tbl[i].e);
    end

    // fill to 32: count is 2 here if rollback worked
    for (int k = 0; k < 29; k++) begin
      @(negedge clk_i);
      idle();
      issue_i = 1;
    end
    @(negedge clk_i);
    idle();
    issue_i = 1;
    #1;
    chk1("full_pre", 32'(full_o), 0);
    @(negedge clk_i);
    idle();
    issue_i = 1;
    #1;
    chk1("full_set", 32'(full_o), 1);
    @(negedge clk_i);
    idle();
    result_valid_i = 1; result_tag_i = 0;
    result_reg_i = 4; result_data_i = 'h44;
    #1;
    chk1("full_hold", 32'(full_o), 1);
    @(negedge clk_i);
    idle();
    #1;
    ex = ow(0, 4, 'h44);
    ex.full = 1'b1;
    chk("retire_when_full", sample(), ex);
    @(negedge clk_i);
    idle();
    issue_i = 1;
    #1;
    chk1("full_clr", 32'(full_o), 0);
    chk1("head_after", 32'(head_tag_o), 1);
    @(negedge clk_i);
    idle();
    #1;
    chk1("full_wrap", 32'(full_o), 1);

    // async reset mid-cycle drops a retiring entry
    result_valid_i = 1; result_tag_i = 1;
    result_reg_i = 8; result_data_i = 'h88;
    @(negedge clk_i);
    idle();
    #1;
    ex = ow(1, 8, 'h88);
    ex.full = 1'b1;
    chk("pre_async_rst", sample(), ex);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("async_rst", sample(), on(0));
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("post_rst", sample(), on(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
